// File: rtl/oled_arb_pkg.sv
// Shared types for the OLED update arbiter: FSM states and grant encodings.
package oled_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_FIN,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_A    = 2'b01,
        GRANT_B    = 2'b10
    } grant_t;

endpackage

// File: rtl/stable_capture.sv
// Source A front end: synchronizes an asynchronous word, waits for it to settle,
// and flags a pending update when the settled word differs from the one last shown.
module stable_capture #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned STABLE_CYCLES = 16   // must be at least 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              take_i,
    output logic [DATA_W-1:0] cand_o,
    output logic              pending_o
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [DATA_W-1:0] sync1_q, sync2_q;
    logic [DATA_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              pending_q, pending_d;
    logic              same;

    // Only the second synchronizer stage feeds any logic; the first may be metastable.
    always_comb begin
        same      = (sync2_q == ref_q);
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        if (!same) begin
            ref_d = sync2_q;
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (same && (cnt_q == CNT_LAST)) begin
            cand_d = ref_q;
        end
        last_d    = take_i ? cand_q : last_q;
        pending_d = !take_i && (cand_q != last_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            ref_q     <= '0;
            cnt_q     <= '0;
            cand_q    <= '0;
            last_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= data_i;
            sync2_q   <= sync1_q;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            last_q    <= last_d;
            pending_q <= pending_d;
        end
    end

    assign cand_o    = cand_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/oled_update_arbiter.sv
// Shares one PmodOLED controller between the I2C slave word (A) and a valid/ready
// requester (B): round-robin grant in IDLE, one update at a time, hold and timeout.
module oled_update_arbiter
    import oled_arb_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned HOLD_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2**20,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_W-1:0]  a_data,
    input  logic               b_valid,
    input  logic [DATA_W-1:0]  b_data,
    output logic               b_ready,
    output logic               oled_en,
    output logic [DATA_W-1:0]  oled_data,
    input  logic               oled_fin,
    output logic [1:0]         grant,
    output logic               busy,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] update_count
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state_q, state_d;
    grant_t              grant_q, grant_d;
    grant_t              last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                b_ready_q, b_ready_d;
    logic                err_q, err_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TO_W-1:0]     to_q, to_d;

    logic [DATA_W-1:0]   a_cand;
    logic                a_pending;
    logic                a_take;
    logic                a_req, b_req, win_a, win_b;
    logic                hold_done, to_done;

    stable_capture #(
        .DATA_W        (DATA_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_capture (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .data_i    (a_data),
        .take_i    (a_take),
        .cand_o    (a_cand),
        .pending_o (a_pending)
    );

    // On a tie the source that did not own the previous update wins.
    always_comb begin
        a_req     = (state_q == IDLE) && a_pending;
        b_req     = (state_q == IDLE) && b_valid;
        win_a     = a_req && (!b_req || (last_grant_q != GRANT_A));
        win_b     = b_req && (!a_req || (last_grant_q == GRANT_A));
        hold_done = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
        to_done   = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (win_a || win_b)       state_d = LOAD;
            LOAD:                               state_d = WAIT_FIN;
            WAIT_FIN: if (oled_fin || to_done)  state_d = HOLD;
            HOLD:     if (hold_done)            state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        oled_en      = (state_q == WAIT_FIN);
        busy         = (state_q != IDLE);
        data_d       = data_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        b_ready_d    = 1'b0;
        err_d        = err_q;
        count_d      = count_q;
        hold_d       = '0;
        to_d         = '0;
        a_take       = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_a) begin
                    data_d       = a_cand;
                    grant_d      = GRANT_A;
                    last_grant_d = GRANT_A;
                    a_take       = 1'b1;
                end else if (win_b) begin
                    data_d       = b_data;
                    grant_d      = GRANT_B;
                    last_grant_d = GRANT_B;
                    b_ready_d    = 1'b1;
                end
            end
            WAIT_FIN: begin
                if (oled_fin) begin
                    count_d = count_q + 1'b1;
                end else if (to_done) begin
                    err_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    grant_d = GRANT_NONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            data_q       <= '0;
            grant_q      <= GRANT_NONE;
            last_grant_q <= GRANT_B;
            b_ready_q    <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            hold_q       <= '0;
            to_q         <= '0;
        end else begin
            data_q       <= data_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            b_ready_q    <= b_ready_d;
            err_q        <= err_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            to_q         <= to_d;
        end
    end

    assign oled_data    = data_q;
    assign grant        = grant_q;
    assign b_ready      = b_ready_q;
    assign timeout_err  = err_q;
    assign update_count = count_q;

endmodule

// File: tb/tb_oled_update_arbiter.sv
// Directed bench for oled_update_arbiter: table of single updates, then tie,
// glitchy source A, timeout, reset during WAIT_FIN and update counter wrap.
module tb_oled_update_arbiter;

    localparam int unsigned STABLE    = 16;
    localparam int unsigned HOLD      = 40;
    localparam int unsigned TMO       = 64;
    localparam int          FIN_DELAY = 50;

    logic        clk;
    logic        rst;
    logic [31:0] a_data, b_data, oled_data;
    logic        b_valid, b_ready, oled_en, oled_fin, busy, timeout_err;
    logic [1:0]  grant;
    logic [15:0] update_count;

    // Narrow-counter instance so a full wrap takes only 16 updates.
    logic        w_rst, w_b_valid, w_b_ready, w_en, w_fin, w_busy, w_err;
    logic [7:0]  w_a, w_b_data, w_data;
    logic [1:0]  w_grant;
    logic [3:0]  w_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;
    int bready_pulses = 0;
    int en_rises = 0;
    logic en_prev = 1'b0;
    bit fin_enable = 1'b1;
    int en_cnt;

    oled_update_arbiter #(
        .DATA_W         (32),
        .STABLE_CYCLES  (STABLE),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .COUNT_W        (16)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .oled_en      (oled_en),
        .oled_data    (oled_data),
        .oled_fin     (oled_fin),
        .grant        (grant),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .update_count (update_count)
    );

    oled_update_arbiter #(
        .DATA_W         (8),
        .STABLE_CYCLES  (2),
        .HOLD_CYCLES    (1),
        .TIMEOUT_CYCLES (16),
        .COUNT_W        (4)
    ) dut_w (
        .CLK          (clk),
        .RST          (w_rst),
        .a_data       (w_a),
        .b_valid      (w_b_valid),
        .b_data       (w_b_data),
        .b_ready      (w_b_ready),
        .oled_en      (w_en),
        .oled_data    (w_data),
        .oled_fin     (w_fin),
        .grant        (w_grant),
        .busy         (w_busy),
        .timeout_err  (w_err),
        .update_count (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Controller model: raises FIN after FIN_DELAY cycles of oled_en when enabled.
    initial begin
        oled_fin = 1'b0;
        en_cnt   = 0;
        forever begin
            @(negedge clk);
            if (oled_en && fin_enable) begin
                en_cnt++;
                oled_fin = (en_cnt >= FIN_DELAY);
            end else begin
                en_cnt   = 0;
                oled_fin = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (b_ready) bready_pulses++;
        if (oled_en && !en_prev) en_rises++;
        en_prev = oled_en;
    end

    typedef struct {
        logic        use_b;
        logic [31:0] word;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Waits for oled_en to reach level; the B source drops b_valid once accepted.
    task automatic wait_en(input logic level, input int bound, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < bound) begin
            @(negedge clk);
            cycles++;
            if (b_ready) b_valid = 1'b0;
            if (oled_en === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_update(input string nm, input logic [1:0] eg,
                                 input logic [31:0] ed, input int elat);
        int cyc;
        int hcyc;
        bit ok;
        wait_en(1'b1, 300, cyc, ok);
        chk({nm, ".start"}, {31'd0, ok}, 32'd1);
        if (!ok) return;
        if (elat >= 0) chk({nm, ".latency"}, cyc, elat);
        chk({nm, ".grant"}, {30'd0, grant}, {30'd0, eg});
        chk({nm, ".data"}, oled_data, ed);
        chk({nm, ".busy"}, {31'd0, busy}, 32'd1);
        wait_en(1'b0, 300, cyc, ok);
        chk({nm, ".finish"}, {31'd0, ok}, 32'd1);
        if (!ok) return;
        exp_count++;
        chk({nm, ".count"}, {16'd0, update_count}, exp_count);
        chk({nm, ".hold_data"}, oled_data, ed);
        chk({nm, ".hold_grant"}, {30'd0, grant}, {30'd0, eg});
        hcyc = 1;
        while (hcyc <= 2 * HOLD) begin
            @(negedge clk);
            if (!busy) break;
            hcyc++;
        end
        chk({nm, ".hold_len"}, hcyc, HOLD);
        chk({nm, ".grant_idle"}, {30'd0, grant}, 32'd0);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, ".oled_en"}, {31'd0, oled_en}, 32'd0);
        chk({nm, ".oled_data"}, oled_data, 32'd0);
        chk({nm, ".b_ready"}, {31'd0, b_ready}, 32'd0);
        chk({nm, ".grant"}, {30'd0, grant}, 32'd0);
        chk({nm, ".busy"}, {31'd0, busy}, 32'd0);
        chk({nm, ".timeout_err"}, {31'd0, timeout_err}, 32'd0);
        chk({nm, ".count"}, {16'd0, update_count}, 32'd0);
    endtask

    initial begin
        int base;
        int cyc;
        int pulses;
        bit ok;

        vecs[0] = '{1'b0, 32'h0000_00A5, 2'b01};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 2'b10};
        vecs[2] = '{1'b0, 32'h8000_0001, 2'b01};
        vecs[3] = '{1'b1, 32'h0000_0000, 2'b10};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 2'b01};
        vecs[5] = '{1'b1, 32'h1234_5678, 2'b10};

        rst = 1'b0;  w_rst = 1'b0;
        a_data = '0; b_data = '0; b_valid = 1'b0;
        w_a = '0; w_b_data = 8'h5A; w_b_valid = 1'b0; w_fin = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;  w_rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].use_b) begin
                b_data  = vecs[i].word;
                b_valid = 1'b1;
            end else begin
                a_data = vecs[i].word;
            end
            expect_update($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].word,
                          vecs[i].use_b ? 2 : int'(STABLE) + 5);
        end

        // Tie: A becomes pending in the same IDLE cycle that B raises valid.
        base = bready_pulses;
        a_data = 32'h11;
        repeat (STABLE + 3) @(negedge clk);
        b_data  = 32'h22;
        b_valid = 1'b1;
        expect_update("tie_a", 2'b01, 32'h11, -1);
        expect_update("tie_b", 2'b10, 32'h22, 2);
        chk("tie.bready_pulses", bready_pulses - base, 1);

        // Glitchy A: never stable long enough until it settles.
        base = en_rises;
        for (int i = 0; i < 20; i++) begin
            a_data = i[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            repeat (5) @(negedge clk);
        end
        chk("glitch.no_update", en_rises - base, 0);
        a_data = 32'h33;
        expect_update("glitch", 2'b01, 32'h33, int'(STABLE) + 5);
        repeat (50) @(negedge clk);
        chk("glitch.one_update", en_rises - base, 1);

        // Timeout: controller never finishes.
        fin_enable = 1'b0;
        b_data  = 32'h44;
        b_valid = 1'b1;
        wait_en(1'b1, 300, cyc, ok);
        chk("timeout.start", {31'd0, ok}, 32'd1);
        wait_en(1'b0, 300, cyc, ok);
        chk("timeout.en_len", cyc, TMO);
        chk("timeout.err", {31'd0, timeout_err}, 32'd1);
        chk("timeout.count", {16'd0, update_count}, exp_count);
        cyc = 0;
        while (busy && cyc < 3 * int'(HOLD)) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout.idle", {31'd0, busy}, 32'd0);
        fin_enable = 1'b1;
        b_data  = 32'h55;
        b_valid = 1'b1;
        expect_update("after_timeout", 2'b10, 32'h55, 2);
        chk("after_timeout.err", {31'd0, timeout_err}, 32'd1);

        // Reset for one cycle while an A update of 0 waits for FIN.
        a_data = 32'h0;
        wait_en(1'b1, 300, cyc, ok);
        chk("rst_mid.start", {31'd0, ok}, 32'd1);
        chk("rst_mid.grant", {30'd0, grant}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b1;
        exp_count = 0;
        base = en_rises;
        repeat (100) @(negedge clk);
        chk("rst_mid.no_update", en_rises - base, 0);
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);

        // Wrap: 16 back-to-back B updates on the 4-bit counter instance.
        pulses = 0;
        ok = 1'b0;
        w_b_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (w_b_ready) pulses++;
            if (pulses == 16) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wrap.reached", {31'd0, ok}, 32'd1);
        chk("wrap.count_before", {28'd0, w_count}, 32'd15);
        chk("wrap.data", {24'd0, w_data}, 32'h5A);
        w_b_valid = 1'b0;
        cyc = 0;
        while (w_busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("wrap.idle", {31'd0, w_busy}, 32'd0);
        chk("wrap.count_after", {28'd0, w_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
